select_pulse_gen: RTL and testbench
===================================

// Module: select_pulse_gen
// PURPOSE
//   Turns a raw, bouncing push-button into clean one-cycle select strobes for the 2-bit selection counter.
//   Three stages, all on clk:
//     - 2-flop synchroniser;
//     - debounce FSM, which emits one strobe per accepted press;
//     - optional auto-repeat while the button is held.
//   Sits between the board button pin and the selection counter's select input.
// PARAMETERS
//   DEBOUNCE_CYCLES  1000000  cycles btn must be stable to accept press/release (>=2)
//   REPEAT_EN        0        1 = generate auto-repeat strobes while held
//   REPEAT_DELAY     50000000 cycles from accepted press to first repeat strobe (>=2)
//   REPEAT_RATE      20000000 cycles between subsequent repeat strobes (>=2)
//   Counter widths: $clog2 of the largest of these values, plus 1.
// PORTS
//   clk         in   1  system clock; all state on posedge
//   reset       in   1  synchronous, active-high reset
//   btn_raw     in   1  asynchronous raw button level, 1 = pressed
//   select_out  out  1  registered strobe, high exactly 1 cycle per press/repeat
//   btn_level   out  1  debounced button level (1 in HELD / RELEASE_WAIT)
// BEHAVIOUR
//   Reset (sync, active-high, at posedge with reset=1):
//     - state=IDLE; sync flops, deb_cnt, rep_cnt, rep_phase all 0;
//     - select_out=0, btn_level=0. Reset overrides all other events.
//   Synchroniser: btn_s = btn_raw delayed by 2 flops. The FSM sees only btn_s.
//   FSM states:
//     IDLE:         btn_s=1 -> PRESS_WAIT, deb_cnt=0.
//     PRESS_WAIT:   btn_s=0 -> IDLE (bounce rejected, no strobe).
//                   Else deb_cnt++.
//                   At deb_cnt==DEBOUNCE_CYCLES-1 -> HELD; select_out<=1; rep_cnt=0; rep_phase=0.
//     HELD:         btn_s=0 -> RELEASE_WAIT, deb_cnt=0. rep_cnt is frozen, not cleared.
//                   Else, if REPEAT_EN:
//                     - rep_cnt++;
//                     - rep_phase=0 and rep_cnt==REPEAT_DELAY-1 -> strobe, rep_cnt=0, rep_phase=1;
//                     - rep_phase=1 and rep_cnt==REPEAT_RATE-1  -> strobe, rep_cnt=0.
//     RELEASE_WAIT: btn_s=1 -> HELD (release bounce, no strobe; rep_cnt resumes).
//                   Else deb_cnt++. At deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//   Latency: btn_raw first sampled 1 at edge N and held stable -> select_out=1 after edge N+DEBOUNCE_CYCLES+2, low after next edge.
//   Strobe spacing:
//     - first repeat strobe is REPEAT_DELAY cycles after the press strobe;
//     - then one every REPEAT_RATE cycles;
//     - time spent in RELEASE_WAIT is excluded.
//   select_out is never high on two consecutive cycles. No strobe is ever generated on release.
//   Reset mid-operation:
//     - FSM returns to IDLE with no strobe;
//     - a button still held after reset deasserts is treated as a new press (full debounce, then one strobe).
//   Counters saturate at their terminal compare values and cannot wrap.
//   REPEAT_EN=0: rep_cnt is held at 0 and repeat logic is inert.
// TESTING
//   (bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5)
//   1) reset=1 for 3 cycles, btn_raw=1 -> select_out=0, btn_level=0 throughout reset.
//   2) REPEAT_EN=0, btn_raw 0->1 at edge 0, held 20 cycles:
//      - select_out high only after edge 6, for 1 cycle;
//      - btn_level=1 from edge 6.
//   3) btn_raw pulses 1 for 3 cycles, then 0, repeated 5 times -> select_out never asserts, btn_level stays 0.
//   4) Held press with release bounce (1-cycle 0 glitches every 2 cycles) -> exactly one strobe; btn_level stays 1.
//   5) REPEAT_EN=1, press held 40 cycles after the first strobe at edge 6 -> strobes after edges 6, 16, 21, 26, 31, 36, 41, 46.
//   6) Assert reset at edge 4 of a press, release reset at edge 6, btn held -> no strobe before edge 12; one strobe after edge 12.

Source files
------------

// File: rtl/select_pulse_gen.sv
// Push-button front end: 2-flop synchroniser, debounce FSM and optional
// auto-repeat, producing one-cycle select strobes for the selection counter.
module select_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic select_out,
    output logic btn_level
);
    localparam int SYNC_STAGES = 2;
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES:0] sync_chain;
    logic                 btn_s;

    state_t               state_reg;
    logic [CW-1:0]        deb_cnt_reg;
    logic [CW-1:0]        rep_cnt_reg;
    logic                 rep_phase_reg;
    logic                 select_reg;
    logic                 level_reg;

    assign sync_chain[0] = btn_raw;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset)
                    sync_chain[gi+1] <= 1'b0;
                else
                    sync_chain[gi+1] <= sync_chain[gi];
            end
        end
    endgenerate

    assign btn_s = sync_chain[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            deb_cnt_reg   <= '0;
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b0;
            select_reg    <= 1'b0;
            level_reg     <= 1'b0;
        end else begin
            select_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg   <= PRESS_WAIT;
                        deb_cnt_reg <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_reg <= IDLE;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        state_reg     <= HELD;
                        select_reg    <= 1'b1;
                        level_reg     <= 1'b1;
                        rep_cnt_reg   <= '0;
                        rep_phase_reg <= 1'b0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    // rep_cnt is left untouched on release so a bounce resumes the repeat timing
                    if (!btn_s) begin
                        state_reg   <= RELEASE_WAIT;
                        deb_cnt_reg <= '0;
                    end else if (REPEAT_EN) begin
                        if (!rep_phase_reg && rep_cnt_reg == DELAY_LAST) begin
                            select_reg    <= 1'b1;
                            rep_cnt_reg   <= '0;
                            rep_phase_reg <= 1'b1;
                        end else if (rep_phase_reg && rep_cnt_reg == RATE_LAST) begin
                            select_reg  <= 1'b1;
                            rep_cnt_reg <= '0;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_reg <= HELD;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        state_reg <= IDLE;
                        level_reg <= 1'b0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign select_out = select_reg;
    assign btn_level  = level_reg;

endmodule

// File: tb/tb_select_pulse_gen.sv
// Bench for select_pulse_gen: two instances (repeat off / on) share one
// stimulus stream and are checked every cycle against a run-length model.
module tb_select_pulse_gen;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic sel0, lvl0, sel1, lvl1;

    int checks = 0;
    int errors = 0;

    // model state
    bit s1, s2;
    bit m_level;
    int m_run;
    int m_hold;
    bit exp_sel0, exp_sel1;

    // per-phase bookkeeping
    int cyc;
    int cnt0, cnt1;
    int first0;

    select_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_dut0 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .select_out(sel0), .btn_level(lvl0)
    );

    select_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) u_dut1 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .select_out(sel1), .btn_level(lvl1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Press accepted after DEB+1 consecutive synchronised samples of 1, release
    // after DEB+1 of 0; repeats fall at held-sample counts RD, RD+RR, RD+2RR, ...
    task automatic model_edge();
        bit s;
        exp_sel0 = 1'b0;
        exp_sel1 = 1'b0;
        if (reset) begin
            s1 = 0; s2 = 0; m_level = 0; m_run = 0; m_hold = 0;
            return;
        end
        s  = s2;
        s2 = s1;
        s1 = btn_raw;
        if (s == m_level) begin
            if (m_level && m_run == 0) begin
                m_hold++;
                if (m_hold >= RD && ((m_hold - RD) % RR) == 0)
                    exp_sel1 = 1'b1;
            end
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_hold   = 0;
                    exp_sel0 = 1'b1;
                    exp_sel1 = 1'b1;
                end
            end
        end
    endtask

    task automatic begin_phase();
        cyc = 0; cnt0 = 0; cnt1 = 0; first0 = -1;
    endtask

    task automatic tick(input bit raw, input bit rst);
        btn_raw = raw;
        reset   = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("sel0", sel0, exp_sel0);
        check("lvl0", lvl0, m_level);
        check("sel1", sel1, exp_sel1);
        check("lvl1", lvl1, m_level);
        if (sel0) begin
            cnt0++;
            if (first0 < 0) first0 = cyc;
        end
        if (sel1) cnt1++;
        $display("cyc=%0d rst=%0b raw=%0b sel0=%0b lvl0=%0b sel1=%0b lvl1=%0b",
                 cyc, rst, raw, sel0, lvl0, sel1, lvl1);
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);

        // 1) reset held with button pressed
        begin_phase();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            check("rst_sel0", sel0, 0);
            check("rst_lvl0", lvl0, 0);
            check("rst_sel1", sel1, 0);
        end

        // 2) and 5) press from edge 0, held through edge 46
        do_reset();
        begin_phase();
        for (int i = 0; i <= 46; i++) tick(1'b1, 1'b0);
        check("press_edge", first0, 6);
        check("press_cnt0", cnt0, 1);
        check("repeat_cnt1", cnt1, 8);
        check("press_lvl", lvl0, 1);

        // 3) short bounces never accepted
        do_reset();
        begin_phase();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        end
        check("bounce_cnt0", cnt0, 0);
        check("bounce_cnt1", cnt1, 0);
        check("bounce_lvl", lvl0, 0);

        // 4) held press with one-cycle release glitches
        do_reset();
        begin_phase();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
        check("glitch_cnt0", cnt0, 1);
        check("glitch_lvl", lvl0, 1);

        // 6) reset in the middle of a press
        do_reset();
        begin_phase();
        for (int i = 0; i <= 14; i++) tick(1'b1, (i == 4 || i == 5));
        check("midrst_edge", first0, 12);
        check("midrst_cnt0", cnt0, 1);

        // random bursts with occasional reset
        do_reset();
        begin_phase();
        for (int seg = 0; seg < 150; seg++) begin
            bit lvl;
            bit rst;
            int len;
            lvl = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 19) == 0);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 7);
            for (int i = 0; i < len; i++) tick(lvl, rst && (i == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
